a2d_spi_resp: RTL

SPI responder that models the 8-channel 12-bit A2D converter at the far end of the A2D interface (A2D_SS_n/A2D_SCLK/A2D_MOSI/A2D_MISO). It is used in fullchip Segway benches and on the FPGA test fixture. It decodes 16-bit command frames from the SPI master. In each frame it returns the conversion of the channel addressed in the *previous* frame, so the master's two-transaction read sequence works unchanged. Per-channel conversion values are loaded through a simple write port by the bench or by a stimulus block.

---
 rtl/a2d_resp_pkg.sv | 24 ++
 rtl/spi_edge_sync.sv | 22 ++
 rtl/a2d_spi_resp.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/a2d_resp_pkg.sv
// a2d_resp_pkg: shared types and constants for the A2D SPI responder.
// Holds FSM states, widths, command field position and LFSR constants.
package a2d_resp_pkg;

  localparam int CH_W   = 3;
  localparam int DATA_W = 12;
  localparam int CH_LSB = 11;
  localparam int CH_MSB = CH_LSB + CH_W - 1;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting form: bits 0,2,3,5 realise taps 16,14,13,11.
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: 3-flop synchronizer with rise/fall strobes in clk domain.
// Flops reset low so a held-low pin after reset never yields a fall strobe.
module spi_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic in_i,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;

  // Shift the pin through two sync stages plus one edge-detect stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], in_i};
  end

  assign rise_o =  sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] &  sync_q[2];

endmodule

// File: rtl/a2d_spi_resp.sv
// a2d_spi_resp: SPI responder modelling an 8-channel 12-bit A2D.
// Define A2D_RESP_DITHER_EN to add LFSR noise on the two response LSBs.
module a2d_spi_resp
  import a2d_resp_pkg::*;
#(
  parameter int              FRAME_BITS = 16,
  parameter logic [CH_W-1:0] RST_CH     = 3'd0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_oe,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DATA_W-1:0] wr_data,
  output logic              cmd_vld,
  output logic [CH_W-1:0]   last_ch,
  output logic              frame_err,
  output logic [7:0]        frame_cnt
);

  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] FULL = CW'(FRAME_BITS);

  logic ss_rise, ss_fall, sclk_rise, sclk_fall;
  logic [1:0] mosi_q;

  state_e                  state_q, state_d;
  logic [FRAME_BITS-1:0]   tx_q, tx_d;
  logic [CH_MSB:0]         rx_q, rx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [CH_W-1:0]         prev_q, prev_d;
  logic [CH_W-1:0]         last_q, last_d;
  logic                    vld_q, vld_d;
  logic                    err_q, err_d;
  logic [7:0]              fcnt_q, fcnt_d;
  logic                    pend_q, pend_d;
  logic [DATA_W-1:0]       tbl_q [8];
  logic [DATA_W-1:0]       dith;
  logic [DATA_W-1:0]       resp;

  spi_edge_sync u_ss (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_i   (SS_n),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  spi_edge_sync u_sclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_i   (SCLK),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  // MOSI only needs the two sync stages; it is sampled on SCLK rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_q <= '0;
    else        mosi_q <= {mosi_q[0], MOSI};
  end

`ifdef A2D_RESP_DITHER_EN
  logic [15:0] lfsr_q;

  // Noise source steps once per completed frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     lfsr_q <= LFSR_SEED;
    else if (vld_d) lfsr_q <= lfsr_next(lfsr_q);
  end

  assign dith = {{(DATA_W-2){1'b0}}, lfsr_q[1:0]};
`else
  assign dith = '0;
`endif

  assign resp = tbl_q[prev_q] ^ dith;

  // Channel value table; a same-clk frame load sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) tbl_q[i] <= '0;
    end else if (wr_en) begin
      tbl_q[wr_ch] <= wr_data;
    end
  end

  // Frame state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      cnt_q   <= '0;
      prev_q  <= RST_CH;
      last_q  <= RST_CH;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      fcnt_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
      last_q  <= last_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      fcnt_q  <= fcnt_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state: load on select, shift on SCLK, close frame in DONE.
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cnt_d   = cnt_q;
    prev_d  = prev_q;
    last_d  = last_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    fcnt_d  = fcnt_q;
    pend_d  = pend_q;
    unique case (state_q)
      IDLE: begin
        pend_d = 1'b0;
        if (ss_fall || pend_q) begin
          state_d = SHIFT;
          tx_d    = {{(FRAME_BITS-DATA_W){1'b0}}, resp};
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (ss_rise) begin
          state_d = DONE;
        end else if (sclk_rise) begin
          rx_d = {rx_q[CH_MSB-1:0], mosi_q[1]};
          if (cnt_q != FULL) cnt_d = cnt_q + 1'b1;
        end else if (sclk_fall && cnt_q != '0) begin
          tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
        end
      end
      DONE: begin
        state_d = IDLE;
        pend_d  = ss_fall;
        if (cnt_q == FULL) begin
          prev_d = rx_q[CH_MSB:CH_LSB];
          last_d = rx_q[CH_MSB:CH_LSB];
          vld_d  = 1'b1;
          fcnt_d = fcnt_q + 8'd1;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign MISO      = tx_q[FRAME_BITS-1];
  assign MISO_oe   = (state_q == SHIFT);
  assign cmd_vld   = vld_q;
  assign frame_err = err_q;
  assign last_ch   = last_q;
  assign frame_cnt = fcnt_q;

endmodule
